// File: rtl/seq_sched_pkg.sv
// Shared types for seq_detect_scheduler: per-channel detector context and helpers.
// Context counters are sized for run lengths up to MAX_RUN_LEN.
package seq_sched_pkg;

   function automatic int run_w(input int run_len);
      return $clog2(run_len + 1);
   endfunction

   localparam int MAX_RUN_LEN = 15;
   localparam int CTX_CNT_W   = run_w(MAX_RUN_LEN);

   typedef struct packed {
      logic                 last;
      logic [CTX_CNT_W-1:0] cnt;
   } ctx_t;

   localparam ctx_t CTX_EMPTY = '{last: 1'b0, cnt: {CTX_CNT_W{1'b0}}};

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester/status bundle of seq_detect_scheduler; master = requesters, slave = scheduler.
interface seq_detect_scheduler_if #(
   parameter int NCH = 4
) ();
   logic [NCH-1:0] req_valid;
   logic [NCH-1:0] req_bit;
   logic [NCH-1:0] clr;
   logic [NCH-1:0] req_ready;
   logic [NCH-1:0] det;
   logic           det_any;
   logic           busy;

   modport master (
      output req_valid, req_bit, clr,
      input  req_ready, det, det_any, busy
   );

   modport slave (
      input  req_valid, req_bit, clr,
      output req_ready, det, det_any, busy
   );
endinterface

// File: rtl/seq_run_update.sv
// Combinational run-length step: folds one bit into a context and flags a full run.
module seq_run_update
   import seq_sched_pkg::*;
#(
   parameter int RUN_LEN = 4
) (
   input  ctx_t ctx,
   input  logic din,
   output ctx_t nxt,
   output logic hit
);
   localparam logic [CTX_CNT_W-1:0] RUN_CAP = CTX_CNT_W'(RUN_LEN);
   localparam logic [CTX_CNT_W-1:0] CNT_ONE = CTX_CNT_W'(1);

   // next context: restart on empty/changed bit, otherwise count up and saturate
   always_comb begin
      nxt = ctx;
      if ((ctx.cnt == {CTX_CNT_W{1'b0}}) || (din != ctx.last)) begin
         nxt.last = din;
         nxt.cnt  = CNT_ONE;
      end else if (ctx.cnt >= RUN_CAP) begin
         nxt.cnt  = RUN_CAP;
      end else begin
         nxt.cnt  = ctx.cnt + CNT_ONE;
      end
      hit = (nxt.cnt == RUN_CAP);
   end
endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one run-length detector among NCH bit-stream channels.
// Optional per-channel saturating hit counters: define SEQ_SCHED_HITCNT_EN.
module seq_detect_scheduler
   import seq_sched_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_detect_scheduler_if.slave  bus
`ifdef SEQ_SCHED_HITCNT_EN
   ,
   output logic [NCH*CNT_W-1:0]   hit_cnt
`endif
);
   localparam int PTR_W = $clog2(NCH);

   logic [PTR_W-1:0] ptr_r;
   ctx_t             ctx_r [NCH];
   logic [NCH-1:0]   cand_s;
   logic [NCH-1:0]   grant_s;
   logic [NCH-1:0]   rdy_s;
   logic [PTR_W-1:0] gidx_s;
   logic             found_s;
   logic             take_s;
   logic             xfer_s;
   ctx_t             nxt_s;
   logic             hit_s;
   logic [NCH-1:0]   det_r;
   logic             det_any_r;
   logic             busy_r;

   assign cand_s = bus.req_valid & ~bus.clr;

   // first candidate at or after ptr, wrapping
   always_comb begin
      grant_s = {NCH{1'b0}};
      gidx_s  = {PTR_W{1'b0}};
      found_s = 1'b0;
      take_s  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         int idx;
         idx          = (int'(ptr_r) + i) % NCH;
         take_s       = !found_s && cand_s[idx];
         grant_s[idx] = take_s;
         gidx_s       = take_s ? PTR_W'(idx) : gidx_s;
         found_s      = found_s | take_s;
      end
   end

   // reset must hold the grant low even before the first edge
   assign rdy_s  = grant_s & {NCH{rst}};
   assign xfer_s = |rdy_s;

   seq_run_update #(.RUN_LEN(RUN_LEN)) u_run (
      .ctx (ctx_r[gidx_s]),
      .din (bus.req_bit[gidx_s]),
      .nxt (nxt_s),
      .hit (hit_s)
   );

   // context array, round-robin pointer and registered status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) ctx_r[i] <= CTX_EMPTY;
         ptr_r     <= {PTR_W{1'b0}};
         det_r     <= {NCH{1'b0}};
         det_any_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.clr[i]) begin
               ctx_r[i] <= CTX_EMPTY;
            end else if (rdy_s[i]) begin
               ctx_r[i] <= nxt_s;
            end
         end
         if (xfer_s) begin
            ptr_r <= (gidx_s == PTR_W'(NCH - 1)) ? {PTR_W{1'b0}} : gidx_s + PTR_W'(1);
         end
         det_r     <= rdy_s & {NCH{hit_s}};
         det_any_r <= xfer_s & hit_s;
         busy_r    <= xfer_s;
      end
   end

   assign bus.req_ready = rdy_s;
   assign bus.det       = det_r;
   assign bus.det_any   = det_any_r;
   assign bus.busy      = busy_r;

`ifdef SEQ_SCHED_HITCNT_EN
   logic [CNT_W-1:0] hit_cnt_r [NCH];

   // per-channel saturating count of detection pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) hit_cnt_r[i] <= {CNT_W{1'b0}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.clr[i]) begin
               hit_cnt_r[i] <= {CNT_W{1'b0}};
            end else if (rdy_s[i] && hit_s && (hit_cnt_r[i] != {CNT_W{1'b1}})) begin
               hit_cnt_r[i] <= hit_cnt_r[i] + CNT_W'(1);
            end
         end
      end
   end

   // flatten counters onto the output bus
   always_comb begin
      hit_cnt = {(NCH*CNT_W){1'b0}};
      for (int i = 0; i < NCH; i++) hit_cnt[i*CNT_W +: CNT_W] = hit_cnt_r[i];
   end
`endif
endmodule
